// File: rtl/l2_cache_pkg.sv
// Shared types and width helpers for the N-way L2 cache.
package l2_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TAG_CHECK = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    localparam int ADDR_W     = 32'd32;
    localparam int LINE_W_DEF = 32'd256;

    typedef logic [LINE_W_DEF-1:0] line_t;

    // Byte-offset field width for a line of line_bits bits.
    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 32'd8);
    endfunction

    // Tag field width left over after set index and byte offset.
    function automatic int tag_bits(input int set_bits, input int line_bits);
        return ADDR_W - set_bits - offset_bits(line_bits);
    endfunction

endpackage

// File: rtl/l2_plru.sv
// Tree pseudo-LRU state: WAYS-1 bits per set, heap-ordered (node n has
// children 2n+1 / 2n+2). A node bit of 1 means the victim lies in the right
// subtree. An access sets every node on its path to point away from it.
module l2_plru #(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4,
    parameter int WAY_W    = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_en,
    input  logic [SET_BITS-1:0] upd_set,
    input  logic [WAY_W-1:0]    upd_way,
    input  logic [SET_BITS-1:0] rd_set,
    output logic [WAY_W-1:0]    victim_way
);

    localparam int SETS   = 32'd1 << SET_BITS;
    localparam int NODES  = WAYS - 32'd1;
    localparam int NODE_W = (WAYS > 32'd2) ? $clog2(NODES) : 32'd1;

    logic [NODES-1:0]  tree_r [SETS];
    logic [NODES-1:0]  upd_tree_s;
    logic [NODES-1:0]  vic_tree_s;
    logic [NODE_W-1:0] upd_node_s;
    logic [NODE_W-1:0] vic_node_s;
    logic [WAY_W-1:0]  victim_s;

    // Walk the accessed way's path from the root, flipping each node away from it.
    always_comb begin
        upd_tree_s = tree_r[upd_set];
        upd_node_s = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            upd_tree_s[upd_node_s] = ~upd_way[l];
            upd_node_s = NODE_W'({upd_node_s, 1'b1}) + NODE_W'(upd_way[l]);
        end
    end

    // Follow the node bits from the root to find the pseudo-LRU way.
    always_comb begin
        vic_tree_s = tree_r[rd_set];
        vic_node_s = '0;
        victim_s   = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            victim_s[l] = vic_tree_s[vic_node_s];
            vic_node_s  = NODE_W'({vic_node_s, 1'b1}) + NODE_W'(vic_tree_s[vic_node_s]);
        end
    end

    assign victim_way = victim_s;

    // Tree bits: cleared on reset, rewritten for the accessed set on a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                tree_r[s] <= '0;
            end
        end else if (upd_en) begin
            tree_r[upd_set] <= upd_tree_s;
        end
    end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back L2 cache with tree-PLRU replacement.
// Optional feature macro: L2_PERF_CNT_EN (hit/miss counters; tied to 0 when
// undefined).
module l2_cache_nway
    import l2_cache_pkg::*;
#(
    parameter int SET_BITS  = 4,
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            mem_address,
    input  logic [LINE_BITS-1:0]   mem_wdata,
    input  logic [LINE_BITS/8-1:0] mem_byte_enable,
    output logic                   mem_resp,
    output logic [LINE_BITS-1:0]   mem_rdata,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [LINE_BITS-1:0]   pmem_wdata,
    input  logic                   pmem_resp,
    input  logic [LINE_BITS-1:0]   pmem_rdata,
    output logic [31:0]            write_back_addr,
    output logic                   if_miss,
    output logic                   miss_sig,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);

    localparam int OFFSET = offset_bits(LINE_BITS);
    localparam int TAG    = tag_bits(SET_BITS, LINE_BITS);
    localparam int SETS   = 32'd1 << SET_BITS;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BYTES  = LINE_BITS / 32'd8;

    // Merge new bytes into a line wherever the byte enable is set.
    function automatic logic [LINE_BITS-1:0] merge_bytes(
        input logic [LINE_BITS-1:0] old_line,
        input logic [LINE_BITS-1:0] new_line,
        input logic [BYTES-1:0]     be
    );
        logic [LINE_BITS-1:0] res;
        res = old_line;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) begin
                res[32'd8 * b +: 8] = new_line[32'd8 * b +: 8];
            end else begin
                res[32'd8 * b +: 8] = old_line[32'd8 * b +: 8];
            end
        end
        return res;
    endfunction

    // Storage: tag/data are never reset; validity and dirtiness are.
    logic [LINE_BITS-1:0] data_arr [WAYS][SETS];
    logic [TAG-1:0]       tag_arr  [WAYS][SETS];
    logic [SETS-1:0]      valid_r  [WAYS];
    logic [SETS-1:0]      dirty_r  [WAYS];

    state_t               state_r;
    logic                 refill_r;
    logic [WAY_W-1:0]     victim_r;
    logic                 pmem_read_r;
    logic                 pmem_write_r;
    logic [31:0]          pmem_address_r;
    logic [31:0]          write_back_addr_r;
    logic [LINE_BITS-1:0] pmem_wdata_r;

    logic [SET_BITS-1:0]  set_s;
    logic [TAG-1:0]       tag_s;
    logic [31:0]          fill_addr_s;
    logic [31:0]          victim_addr_s;
    logic                 tag_check_s;
    logic                 hit_s;
    logic [WAY_W-1:0]     hit_way_s;
    logic                 inv_found_s;
    logic [WAY_W-1:0]     inv_way_s;
    logic [WAY_W-1:0]     plru_victim_s;
    logic [WAY_W-1:0]     victim_s;
    logic                 wr_hit_s;
    logic                 fill_done_s;
    logic                 unused_s;

    assign set_s         = mem_address[OFFSET +: SET_BITS];
    assign tag_s         = mem_address[31 -: TAG];
    assign fill_addr_s   = {mem_address[31:OFFSET], {OFFSET{1'b0}}};
    assign tag_check_s   = (state_r == TAG_CHECK);
    assign victim_s      = inv_found_s ? inv_way_s : plru_victim_s;
    assign victim_addr_s = {tag_arr[victim_s][set_s], set_s, {OFFSET{1'b0}}};
    // Simultaneous read and write is handled as a write.
    assign wr_hit_s      = tag_check_s && hit_s && mem_write;
    assign fill_done_s   = (state_r == FILL) && pmem_resp;
    assign unused_s      = ^{mem_address[OFFSET-1:0], refill_r};

    // Tag compare across ways and lowest-index invalid way search.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[w][set_s] && (tag_arr[w][set_s] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
                hit_way_s = hit_way_s;
            end
            if (!valid_r[w][set_s]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_found_s = inv_found_s;
                inv_way_s   = inv_way_s;
            end
        end
    end

    l2_plru #(
        .SET_BITS (SET_BITS),
        .WAYS     (WAYS),
        .WAY_W    (WAY_W)
    ) u_plru (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_en     (tag_check_s && hit_s),
        .upd_set    (set_s),
        .upd_way    (hit_way_s),
        .rd_set     (set_s),
        .victim_way (plru_victim_s)
    );

    // Control FSM; pmem strobes, address and victim data are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            refill_r          <= 1'b0;
            victim_r          <= '0;
            pmem_read_r       <= 1'b0;
            pmem_write_r      <= 1'b0;
            pmem_address_r    <= 32'd0;
            write_back_addr_r <= 32'd0;
            pmem_wdata_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    refill_r <= 1'b0;
                    if (mem_read || mem_write) begin
                        state_r <= TAG_CHECK;
                    end
                end
                TAG_CHECK: begin
                    if (hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        victim_r <= victim_s;
                        if (valid_r[victim_s][set_s] && dirty_r[victim_s][set_s]) begin
                            state_r           <= WRITEBACK;
                            pmem_write_r      <= 1'b1;
                            pmem_address_r    <= victim_addr_s;
                            write_back_addr_r <= victim_addr_s;
                            pmem_wdata_r      <= data_arr[victim_s][set_s];
                        end else begin
                            state_r        <= FILL;
                            pmem_read_r    <= 1'b1;
                            pmem_address_r <= fill_addr_s;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_r           <= FILL;
                        pmem_write_r      <= 1'b0;
                        write_back_addr_r <= 32'd0;
                        pmem_wdata_r      <= '0;
                        pmem_read_r       <= 1'b1;
                        pmem_address_r    <= fill_addr_s;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_r        <= TAG_CHECK;
                        pmem_read_r    <= 1'b0;
                        pmem_address_r <= 32'd0;
                        refill_r       <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Line and tag storage: fill load or byte-merged write hit.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            data_arr[victim_r][set_s] <= pmem_rdata;
            tag_arr[victim_r][set_s]  <= tag_s;
        end else if (wr_hit_s) begin
            data_arr[hit_way_s][set_s] <= merge_bytes(data_arr[hit_way_s][set_s],
                                                      mem_wdata, mem_byte_enable);
        end
    end

    // Valid/dirty bits: a fill validates a clean line, a write hit dirties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
                dirty_r[w] <= '0;
            end
        end else if (fill_done_s) begin
            valid_r[victim_r][set_s] <= 1'b1;
            dirty_r[victim_r][set_s] <= 1'b0;
        end else if (wr_hit_s) begin
            dirty_r[hit_way_s][set_s] <= 1'b1;
        end
    end

    assign mem_resp        = tag_check_s && hit_s;
    assign mem_rdata       = mem_resp ? data_arr[hit_way_s][set_s] : '0;
    assign if_miss         = tag_check_s && !hit_s;
    assign pmem_read       = pmem_read_r;
    assign pmem_write      = pmem_write_r;
    assign pmem_address    = pmem_address_r;
    assign pmem_wdata      = pmem_wdata_r;
    assign write_back_addr = write_back_addr_r;
    assign miss_sig        = pmem_read_r;

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Count first-pass hits (not the hit that follows a fill) and misses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (tag_check_s && hit_s && !refill_r) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (if_miss) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
